// File: rtl/fcims_restock.sv
// fcims_restock: restock cost calculator for one item.
// Accepts a restock request and clips the quantity to the free room below CAP.
// Prices the accepted quantity with a 4-cycle shift-add multiply and keeps a
// running total of spend.
// Optional feature: define FCIMS_RESTOCK_SAT_EN to make the running total
// saturate at 255. The default build wraps modulo 256.
module fcims_restock #(
  parameter int CAP = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] uprice,
  input  logic [3:0] nadd,
  input  logic [3:0] ct,
  input  logic       tcost_clr,
  output logic       rsp_valid,
  output logic [7:0] cost,
  output logic [3:0] new_ct,
  output logic [7:0] tcost,
  output logic       full,
  output logic       clipped
);

  localparam logic [3:0] CAP_V = 4'(CAP);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t      state, next_state;
  logic        accept, mul_step, resp_load;
  logic [3:0]  room, qty;
  logic [2:0]  cnt;
  logic [7:0]  mcand, acc;
  logic [3:0]  mplier;
  logic [3:0]  new_ct_pend;
  logic        clip_pend;
  logic [8:0]  tsum;
  logic [7:0]  tnext;

  // Next-state and handshake decode.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    mul_step   = 1'b0;
    resp_load  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = MUL;
        end
      end
      MUL: begin
        if (cnt == 3'd4) begin
          resp_load  = 1'b1;
          next_state = RESP;
        end else begin
          mul_step = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Quantity clipping and running-total arithmetic.
  always_comb begin
    room  = (ct < CAP_V) ? (CAP_V - ct) : 4'd0;
    qty   = (nadd < room) ? nadd : room;
    // Clear-then-add when a clear lands on the response edge.
    tsum  = {1'b0, (tcost_clr ? 8'd0 : tcost)} + {1'b0, acc};
`ifdef FCIMS_RESTOCK_SAT_EN
    tnext = tsum[8] ? 8'hFF : tsum[7:0];
`else
    tnext = tsum[7:0];
`endif
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath: capture, shift-add multiply, response and running-total registers.
  // NOTE: all datapath registers are reset so an abandoned request leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      new_ct_pend <= '0;
      clip_pend   <= 1'b0;
      rsp_valid   <= 1'b0;
      cost        <= '0;
      new_ct      <= '0;
      tcost       <= '0;
      full        <= 1'b0;
      clipped     <= 1'b0;
    end else begin
      rsp_valid <= resp_load;
      if (accept) begin
        cnt         <= '0;
        acc         <= '0;
        mcand       <= {4'd0, uprice};
        mplier      <= qty;
        new_ct_pend <= (ct >= CAP_V) ? CAP_V : (ct + qty);
        clip_pend   <= (qty < nadd);
      end
      if (mul_step) begin
        acc    <= acc + (mplier[0] ? mcand : 8'd0);
        mcand  <= {mcand[6:0], 1'b0};
        mplier <= {1'b0, mplier[3:1]};
        cnt    <= cnt + 3'd1;
      end
      if (resp_load) begin
        cost    <= acc;
        new_ct  <= new_ct_pend;
        full    <= (new_ct_pend == CAP_V);
        clipped <= clip_pend;
        tcost   <= tnext;
      end else if (tcost_clr) begin
        tcost <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fcims_restock.sv
// Scoreboard bench for fcims_restock: the driver pushes hand-computed
// responses into a queue, and a monitor pops and compares on each rsp_valid.
module tb_fcims_restock;

  typedef struct packed {
    logic [7:0] cost;
    logic [3:0] new_ct;
    logic [7:0] tcost;
    logic       full;
    logic       clipped;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] uprice = '0, nadd = '0, ct = '0;
  logic       tcost_clr = 1'b0;
  logic       rsp_valid;
  logic [7:0] cost, tcost;
  logic [3:0] new_ct;
  logic       full, clipped;

  int   n_pass = 0;
  int   n_total = 0;
  rsp_t exp_q[$];

`ifdef FCIMS_RESTOCK_SAT_EN
  localparam logic [7:0] OVF_TCOST = 8'd255;
`else
  localparam logic [7:0] OVF_TCOST = 8'd194;
`endif

  fcims_restock #(.CAP(15)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .uprice(uprice), .nadd(nadd), .ct(ct), .tcost_clr(tcost_clr),
    .rsp_valid(rsp_valid), .cost(cost), .new_ct(new_ct), .tcost(tcost),
    .full(full), .clipped(clipped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("cost",    cost,    e.cost);
        check("new_ct",  new_ct,  e.new_ct);
        check("tcost",   tcost,   e.tcost);
        check("full",    full,    e.full);
        check("clipped", clipped, e.clipped);
      end
    end
  end

  task automatic push(input int c, input int n, input int t, input int f, input int cl);
    rsp_t e;
    e.cost = 8'(c); e.new_ct = 4'(n); e.tcost = 8'(t); e.full = 1'(f); e.clipped = 1'(cl);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_cost"},      cost,      0);
    check({tag, "_new_ct"},    new_ct,    0);
    check({tag, "_tcost"},     tcost,     0);
    check({tag, "_full"},      full,      0);
    check({tag, "_clipped"},   clipped,   0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  // mode 0: plain request; mode 1: extra req_valid pulse during MUL;
  // mode 2: tcost_clr asserted on the response edge.
  task automatic do_req(input logic [3:0] up, input logic [3:0] na,
                        input logic [3:0] c, input int mode);
    int lat;
    @(negedge clk);
    uprice = up; nadd = na; ct = c; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("ready_busy", req_ready, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (mode == 1 && i == 2) begin
        req_valid = 1'b1; uprice = 4'd1; nadd = 4'd1; ct = 4'd0;
      end
      if (mode == 2 && i == 5) tcost_clr = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      tcost_clr = 1'b0;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 5);
    check("ready_in_resp", req_ready, 0);
    @(posedge clk);
    #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    do_reset();
    #1 check_idle_zero("reset");

    // Normal restock.
    push(12, 6, 12, 0, 0);
    do_req(4'd3, 4'd4, 4'd2, 0);

    // Clipped restock into full.
    push(27, 15, 39, 1, 1);
    do_req(4'd9, 4'd6, 4'd12, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_cost", cost, 27);
    check("hold_new_ct", new_ct, 15);
    check("hold_full", full, 1);

    // Already full; req_valid during MUL is ignored.
    push(0, 15, 39, 1, 1);
    do_req(4'd7, 4'd5, 4'd15, 1);
    repeat (8) @(posedge clk);

    // nadd=0: no clip, zero cost.
    push(0, 5, 39, 0, 0);
    do_req(4'd4, 4'd0, 4'd5, 0);

    // Standalone clear.
    @(negedge clk) tcost_clr = 1'b1;
    @(posedge clk);
    #1 tcost_clr = 1'b0;
    check("clr_tcost", tcost, 0);

    // Clear coinciding with a response edge (clear-then-add).
    check("pre_clr_tcost_zero", tcost, 0);
    push(30, 15, 30, 1, 0);
    do_req(4'd2, 4'd15, 4'd0, 0);
    push(6, 3, 6, 0, 0);
    do_req(4'd2, 4'd3, 4'd0, 2);

    // Overflow of the running total.
    do_reset();
    push(225, 15, 225, 1, 0);
    do_req(4'd15, 4'd15, 4'd0, 0);
    push(225, 15, OVF_TCOST, 1, 0);
    do_req(4'd15, 4'd15, 4'd0, 0);

    // Reset during MUL abandons the request.
    @(negedge clk);
    uprice = 4'd5; nadd = 4'd2; ct = 4'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    check_idle_zero("midrst");
    repeat (10) @(posedge clk);
    push(10, 3, 10, 0, 0);
    do_req(4'd5, 4'd2, 4'd1, 0);

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fcims_restock.md
FCIMS_RESTOCK -- requirements
Module: fcims_restock

Interface
REQ-001 The block SHALL have parameter CAP, default 15, meaning maximum stock count per item (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, restock request present.
REQ-005 The block SHALL have port req_ready, output, 1, block idle and able to accept a request.
REQ-006 The block SHALL have port uprice, input, 4, supplier unit price.
REQ-007 The block SHALL have port nadd, input, 4, requested restock quantity.
REQ-008 The block SHALL have port ct, input, 4, current stock count.
REQ-009 The block SHALL have port tcost_clr, input, 1, synchronous clear of the accumulated spend.
REQ-010 The block SHALL have port rsp_valid, output, 1, one-cycle result strobe.
REQ-011 The block SHALL have port cost, output, 8, uprice times accepted quantity.
REQ-012 The block SHALL have port new_ct, output, 4, stock count after restock.
REQ-013 The block SHALL have port tcost, output, 8, accumulated restock spend.
REQ-014 The block SHALL have port full, output, 1, new_ct equals CAP.
REQ-015 The block SHALL have port clipped, output, 1, accepted quantity is less than nadd.

Function
REQ-016 The FSM SHALL have states IDLE, MUL and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in MUL and RESP, req_ready SHALL be 0.
REQ-018 A request SHALL be accepted only at an edge where state=IDLE and req_valid=1; uprice, nadd and ct are captured at that edge (edge 0).
REQ-019 At acceptance the block SHALL compute room = CAP-ct if ct<CAP, else 0, and qty = min(nadd, room).
REQ-020 MUL SHALL run an unsigned 4x4 shift-add multiply of uprice by qty, one multiplier bit per edge, at edges 1..4.
REQ-021 At edge 5 the block SHALL register cost, new_ct=ct+qty, full, clipped and the tcost update, enter RESP and drive rsp_valid=1.
REQ-022 At edge 6 the block SHALL clear rsp_valid and return to IDLE; rsp_valid is high for exactly one cycle per accepted request.
REQ-023 req_valid SHALL be ignored while in MUL or RESP; no queuing.
REQ-024 cost, new_ct, full and clipped SHALL hold their values between responses.
REQ-025 The tcost update SHALL be tcost+cost, 9-bit intermediate, with overflow handled per REQ-032/REQ-033.
REQ-026 For qty=0 (nadd=0, or ct>=CAP), the block SHALL still respond with cost=0 and new_ct=ct if ct<=CAP, else CAP; clipped=1 iff nadd>0.
REQ-027 tcost_clr=1 without a response update SHALL set tcost=0; if it coincides with edge 5, tcost SHALL equal the cost of that response (clear-then-add).

Reset
REQ-028 When reset=0 at an edge, the block SHALL set state=IDLE, req_ready=1, rsp_valid=0, cost=0, new_ct=0, tcost=0, full=0, clipped=0, and clear the multiplier counter and accumulator.
REQ-029 Reset during MUL or RESP SHALL abandon the request; no rsp_valid pulse for it after reset is released.
REQ-030 reset SHALL take priority over req_valid and tcost_clr.
REQ-031 A request SHALL not be accepted at any edge where reset=0.

Configuration
REQ-032 With macro FCIMS_RESTOCK_SAT_EN defined, tcost SHALL saturate at 255.
REQ-033 Without FCIMS_RESTOCK_SAT_EN, tcost SHALL wrap modulo 256.

Verification
REQ-034 Reset case: hold reset=0 for 2 cycles, then 1 -> all outputs 0, req_ready=1, rsp_valid=0.
REQ-035 Normal restock: uprice=3, nadd=4, ct=2 -> at edge 5: cost=12, new_ct=6, full=0, clipped=0, tcost=12; rsp_valid high one cycle; req_ready=1 after edge 6.
REQ-036 Clipped restock: following REQ-035, uprice=9, nadd=6, ct=12 -> qty=3, cost=27, new_ct=15, full=1, clipped=1, tcost=39.
REQ-037 Already-full stock: ct=15, nadd=5, uprice=7 -> cost=0, new_ct=15, full=1, clipped=1, tcost unchanged; also req_valid pulsed during MUL is ignored.
REQ-038 Overflow case: after reset, two requests of uprice=15, nadd=15, ct=0 -> each cost=225; final tcost=255 with FCIMS_RESTOCK_SAT_EN, 194 without.
REQ-039 Mid-operation reset: reset=0 at edge 3 after acceptance -> no rsp_valid, outputs 0, req_ready=1; a subsequent request is processed normally.
